// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch path: word/byte-address types and
// the response record carried through the response buffer.
package fetch_pkg;
    typedef logic [31:0] word_t;
    typedef logic [31:0] baddr_t;

    localparam int    WORD_BYTES       = 4;
    localparam word_t ERR_WORD_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        word_t  data;
        logic   err;
        baddr_t addr;
    } fetch_resp_t;
endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO of fetch responses with a count output;
// the head entry is presented combinationally on pop_data.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fetch_resp_t push_data,
    input  logic        pop,
    output fetch_resp_t pop_data,
    output logic        full,
    output logic        empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_resp_t       store [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch_responder.sv
// Registered, flow-controlled instruction-fetch responder: one read stage
// feeding an in-order response buffer, with a program-load write port.
module instr_fetch_responder
    import fetch_pkg::*;
#(
    parameter  int    DEPTH_WORDS = 256,
    parameter  int    FIFO_DEPTH  = 2,
    parameter  word_t ERR_WORD    = ERR_WORD_DEFAULT,
    localparam int    AW          = $clog2(DEPTH_WORDS),
    localparam int    OW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  baddr_t        req_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output word_t         resp_data,
    output logic          resp_err,
    output baddr_t        resp_addr,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  word_t         ld_data,
    output logic [OW-1:0] outstanding
);
    word_t       mem [DEPTH_WORDS];
    logic        accept, req_err;
    logic        s1_valid, s1_err;
    baddr_t      s1_addr;
    word_t       rd_word;
    fetch_resp_t s1_resp, fifo_head, head;
    logic        pop, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [OW-1:0] fifo_count;

    assign req_err = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign accept  = req_valid && req_ready;

    // Non-blocking write gives read-before-write when load and fetch collide.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_addr  <= '0;
            rd_word  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err  <= req_err;
                s1_addr <= req_addr;
                rd_word <= mem[req_addr[AW+1:2]];
            end
        end
    end

    assign s1_resp = '{data: s1_err ? ERR_WORD : rd_word, err: s1_err, addr: s1_addr};

    // The read stage is the youngest entry: it bypasses to the head when the
    // buffer is empty, otherwise it drains into the buffer the next edge.
    assign head       = fifo_empty ? s1_resp : fifo_head;
    assign resp_valid = !fifo_empty || s1_valid;
    assign pop        = resp_valid && resp_ready;
    assign fifo_pop   = pop && !fifo_empty;
    assign fifo_push  = s1_valid && !(pop && fifo_empty);

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (s1_resp),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign outstanding = fifo_count + OW'(s1_valid);
    assign req_ready   = (outstanding < OW'(FIFO_DEPTH));
    assign resp_data   = head.data;
    assign resp_err    = head.err;
    assign resp_addr   = head.addr;

    a_out_bound: assert property (@(posedge clk) disable iff (reset)
        outstanding <= OW'(FIFO_DEPTH));
    a_no_full_push: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full));
    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        resp_valid && !resp_ready |=> resp_valid && $stable(resp_data) &&
        $stable(resp_err) && $stable(resp_addr));
endmodule
